// File: rtl/reg_wb_arbiter_if.sv
// Writeback arbiter bus bundle: two writeback requesters, the register-file write
// port, and the decode-side issue/read ports used for stall detection.
interface reg_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  // Requester A (ALU writeback)
  logic              a_valid;
  logic [ADDR_W-1:0] a_wn;
  logic [DATA_W-1:0] a_wd;
  logic              a_ready;

  // Requester B (load / multicycle writeback)
  logic              b_valid;
  logic [ADDR_W-1:0] b_wn;
  logic [DATA_W-1:0] b_wd;
  logic              b_ready;

  // Register-file write port
  logic              RegWrite;
  logic [ADDR_W-1:0] WN;
  logic [DATA_W-1:0] WD;

  // Decode side
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_wn;
  logic [ADDR_W-1:0] RN1;
  logic [ADDR_W-1:0] RN2;
  logic              stall;

  modport slave (
    input  a_valid, a_wn, a_wd,
    output a_ready,
    input  b_valid, b_wn, b_wd,
    output b_ready,
    output RegWrite, WN, WD,
    input  iss_valid, iss_wn, RN1, RN2,
    output stall
  );

  modport master (
    output a_valid, a_wn, a_wd,
    input  a_ready,
    output b_valid, b_wn, b_wd,
    input  b_ready,
    input  RegWrite, WN, WD,
    output iss_valid, iss_wn, RN1, RN2,
    input  stall
  );

endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writeback, with a registered write stage and a pending-destination scoreboard.
module reg_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  reg_wb_arbiter_if.slave bus
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e              r_pri;
  pri_e              w_pri_nxt;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wn;
  logic [DATA_W-1:0] w_wd;

  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wn;
  logic [DATA_W-1:0] r_wd;

  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;

  // Priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pri <= PRI_A;
    end else begin
      r_pri <= w_pri_nxt;
    end
  end

  // Grant decode and priority rotation; readies are forced low while in reset
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    w_pri_nxt = r_pri;
    if (rst_n) begin
      case ({bus.a_valid, bus.b_valid})
        2'b10:   w_grant_a = 1'b1;
        2'b01:   w_grant_b = 1'b1;
        2'b11: begin
          w_grant_a = (r_pri == PRI_A);
          w_grant_b = (r_pri == PRI_B);
        end
        default: ;
      endcase
    end
    if (w_grant_a) begin
      w_pri_nxt = PRI_B;
    end else if (w_grant_b) begin
      w_pri_nxt = PRI_A;
    end
  end

  // Winner's payload; a write to register 0 is handshaken but never reaches reg_file
  always_comb begin
    w_wn = '0;
    w_wd = '0;
    if (w_grant_a) begin
      w_wn = bus.a_wn;
      w_wd = bus.a_wd;
    end else if (w_grant_b) begin
      w_wn = bus.b_wn;
      w_wd = bus.b_wd;
    end
    w_wr_en = (w_grant_a | w_grant_b) & (w_wn != '0);
  end

  // Output stage: one-cycle write pulse, WN/WD hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite <= 1'b0;
      r_wn       <= '0;
      r_wd       <= '0;
    end else begin
      r_regwrite <= w_wr_en;
      if (w_wr_en) begin
        r_wn <= w_wn;
        r_wd <= w_wd;
      end
    end
  end

  // Scoreboard: clear on the reg_file write edge, then set on issue so set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_regwrite) begin
      w_busy_nxt[r_wn] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_wn != '0)) begin
      w_busy_nxt[bus.iss_wn] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.a_ready  = w_grant_a;
  assign bus.b_ready  = w_grant_b;
  assign bus.RegWrite = r_regwrite;
  assign bus.WN       = r_wn;
  assign bus.WD       = r_wd;
  // busy[0] is never set, so reading r0 cannot stall
  assign bus.stall    = r_busy[bus.RN1] | r_busy[bus.RN2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: a driver applies directed and random traffic
// and queues predictions from a reference model; a monitor compares each cycle.
module tb_reg_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct {
    logic ar;
    logic br;
    logic st;
  } comb_t;

  typedef struct {
    int          cyc;
    logic [4:0]  wn;
    logic [31:0] wd;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   mon_en;

  comb_t q_comb[$];
  wr_t   q_out[$];
  comb_t me;
  wr_t   mw;

  // Reference model state
  bit        m_pri;          // 0: A wins a tie, 1: B wins a tie
  bit [31:0] m_busy;         // destinations issued and not yet written
  bit        m_pend_v;       // write reaching reg_file in the current cycle
  bit [4:0]  m_pend_wn;
  bit        last_ga;
  bit        last_gb;

  reg_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one combinational prediction per cycle, and a write prediction
  // whenever one is due in this cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_comb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL comb_queue_empty: got none expected one (cycle %0d)", cyc);
      end else begin
        me = q_comb.pop_front();
        chk("a_ready", 32'(bus.a_ready), 32'(me.ar));
        chk("b_ready", 32'(bus.b_ready), 32'(me.br));
        chk("stall",   32'(bus.stall),   32'(me.st));
      end
      if (q_out.size() != 0 && q_out[0].cyc == cyc) begin
        mw = q_out.pop_front();
        chk("RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("WN", 32'(bus.WN), 32'(mw.wn));
        chk("WD", bus.WD, mw.wd);
      end else begin
        chk("RegWrite_idle", 32'(bus.RegWrite), 32'd0);
      end
    end
  end

  // One cycle of traffic: predict this cycle's response, advance the model, move on
  task automatic step();
    bit ga;
    bit gb;
    bit st;
    ga = bus.a_valid && (!bus.b_valid || m_pri == 1'b0);
    gb = bus.b_valid && (!bus.a_valid || m_pri == 1'b1);
    st = m_busy[bus.RN1] || m_busy[bus.RN2];
    q_comb.push_back('{ga, gb, st});
    m_busy[m_pend_wn] = m_busy[m_pend_wn] & !m_pend_v;
    if (bus.iss_valid && bus.iss_wn != 5'd0) m_busy[bus.iss_wn] = 1'b1;
    m_pend_v = 1'b0;
    if (ga) begin
      if (bus.a_wn != 5'd0) q_out.push_back('{cyc + 1, bus.a_wn, bus.a_wd});
      m_pend_v  = (bus.a_wn != 5'd0);
      m_pend_wn = bus.a_wn;
      m_pri = 1'b1;
    end else if (gb) begin
      if (bus.b_wn != 5'd0) q_out.push_back('{cyc + 1, bus.b_wn, bus.b_wd});
      m_pend_v  = (bus.b_wn != 5'd0);
      m_pend_wn = bus.b_wn;
      m_pri = 1'b0;
    end
    last_ga = ga;
    last_gb = gb;
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input bit v, input logic [4:0] wn, input logic [31:0] wd);
    bus.a_valid = v; bus.a_wn = wn; bus.a_wd = wd;
  endtask

  task automatic set_b(input bit v, input logic [4:0] wn, input logic [31:0] wd);
    bus.b_valid = v; bus.b_wn = wn; bus.b_wd = wd;
  endtask

  task automatic set_dec(input bit iv, input logic [4:0] iwn, input logic [4:0] r1,
                         input logic [4:0] r2);
    bus.iss_valid = iv; bus.iss_wn = iwn; bus.RN1 = r1; bus.RN2 = r2;
  endtask

  task automatic clear_inputs();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic model_reset();
    q_comb.delete();
    q_out.delete();
    m_pri = 1'b0; m_busy = '0; m_pend_v = 1'b0; m_pend_wn = 5'd0;
    last_ga = 1'b0; last_gb = 1'b0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for a clock
  task automatic apply_reset();
    mon_en = 1'b0;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_ready",  32'(bus.a_ready),  32'd0);
    chk("rst_b_ready",  32'(bus.b_ready),  32'd0);
    chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_WN",       32'(bus.WN),       32'd0);
    chk("rst_WD",       bus.WD,            32'd0);
    chk("rst_stall",    32'(bus.stall),    32'd0);
    model_reset();
    @(posedge clk);
    clear_inputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    chk("init_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("init_WN",       32'(bus.WN),       32'd0);
    chk("init_WD",       bus.WD,            32'd0);
    chk("init_stall",    32'(bus.stall),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single A write: ready now, write pulse next cycle only
    set_a(1'b1, 5'd1, 32'd200); step();
    set_a(1'b0, 5'd0, 32'd0);   step();
    step();

    // Pending destination stalls decode until the edge that writes it
    set_dec(1'b1, 5'd7, 5'd0, 5'd0); step();
    set_dec(1'b0, 5'd0, 5'd7, 5'd0); step();
    set_a(1'b1, 5'd7, 32'h77);       step();
    set_a(1'b0, 5'd0, 32'd0);        step();
    step();
    step();

    // Re-issue of a register on its write edge keeps it busy
    set_dec(1'b1, 5'd7, 5'd0, 5'd0); step();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0);
    set_a(1'b1, 5'd7, 32'h1234);     step();
    set_a(1'b0, 5'd0, 32'd0);
    set_dec(1'b1, 5'd7, 5'd0, 5'd0); step();
    set_dec(1'b0, 5'd0, 5'd7, 5'd0); step();
    step();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0);

    // Write to r0: handshake completes, no reg_file write, priority still rotates
    set_a(1'b1, 5'd0, 32'd5);  step();
    set_a(1'b1, 5'd2, 32'd11);
    set_b(1'b1, 5'd3, 32'd22); step();
    set_b(1'b0, 5'd0, 32'd0);  step();
    set_a(1'b0, 5'd0, 32'd0);  step();

    // Reset while a write is in the output stage and a read is stalled
    set_dec(1'b1, 5'd4, 5'd0, 5'd0); step();
    set_dec(1'b0, 5'd0, 5'd4, 5'd0);
    set_a(1'b1, 5'd5, 32'd77);       step();
    apply_reset();

    // Both requesters valid continuously from reset: strict alternation A,B,A,B
    set_a(1'b1, 5'd7, 32'd300);
    set_b(1'b1, 5'd9, 32'd400);
    for (int i = 0; i < 6; i++) step();
    clear_inputs();
    step();

    // Random traffic; a requester only changes its write once granted
    for (int i = 0; i < 400; i++) begin
      if (!bus.a_valid || last_ga)
        set_a(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      if (!bus.b_valid || last_gb)
        set_b(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      set_dec(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    clear_inputs();
    step();
    step();

    mon_en = 1'b0;
    chk("undelivered_writes", 32'(q_out.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
